// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grant with bus parking, grant timeout
// and hidden arbitration. Observes Frame/IRDY only; drives no bus signals.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_MASTER = 0
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_MASTERS-1:0]         Req,
    input  logic                           Frame,
    input  logic                           IRDY,
    output logic [NUM_MASTERS-1:0]         Gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] Owner,
    output logic                           BusIdle,
    output logic [1:0]                     State
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(GNT_TIMEOUT);
    localparam logic [CW-1:0] TO_M1  = CW'(GNT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SWITCH   = 2'd0,
        GNT_WAIT = 2'd1,
        BUSY     = 2'd2
    } state_t;

    state_t                   state, state_nx;
    logic [OW-1:0]            owner, owner_nx;
    logic [CW-1:0]            cnt, cnt_nx;
    logic [NUM_MASTERS-1:0]   gnt, gnt_nx;
    logic                     bus_idle_q;

    logic                     idle;
    logic                     win_vld;
    logic [OW-1:0]            winner;
    logic [OW-1:0]            cand;
    logic                     other_req;

    assign idle = Frame & IRDY;

    // Search Owner+1 .. Owner (mod N); the current owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        winner  = owner;
        cand    = owner;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = OW'((int'(owner) + k) % NUM_MASTERS);
            if (!win_vld && !Req[cand]) begin
                win_vld = 1'b1;
                winner  = cand;
            end
        end
    end

    assign other_req = win_vld && (winner != owner);

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        cnt_nx   = cnt;
        case (state)
            SWITCH: begin
                state_nx = GNT_WAIT;
                cnt_nx   = '0;
                if (win_vld) owner_nx = winner;
            end
            GNT_WAIT: begin
                // A transaction start beats a simultaneous switch decision.
                if (!Frame) begin
                    state_nx = BUSY;
                    cnt_nx   = '0;
                end else if (other_req && Req[owner]) begin
                    state_nx = SWITCH;
                end else if (idle) begin
                    if (cnt >= TO_M1 && other_req) state_nx = SWITCH;
                    if (cnt != TO_MAX) cnt_nx = cnt + 1'b1;
                end
            end
            BUSY: begin
                if (other_req) begin
                    state_nx = SWITCH;
                end else if (idle) begin
                    state_nx = GNT_WAIT;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = SWITCH;
        endcase
    end

    always_comb begin
        gnt_nx = '1;
        if (state_nx != SWITCH) gnt_nx[owner_nx] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= SWITCH;
            owner      <= OW'(PARK_MASTER);
            cnt        <= '0;
            gnt        <= '1;
            bus_idle_q <= 1'b1;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            cnt        <= cnt_nx;
            gnt        <= gnt_nx;
            bus_idle_q <= idle;
        end
    end

    assign Gnt     = gnt;
    assign Owner   = owner;
    assign BusIdle = bus_idle_q;
    assign State   = state;

endmodule
